hex_display_ctrl: RTL and testbench

//  Avalon-MM slave driving NUM_DIGITS 7-segment digits from the NIOS CPU. Parametrised successor of the single-digit PIO.
//  - Per-digit hex-nibble decode or raw-segment mode, per-digit blanking, optional blink.
//  - Sits on the CPU data bus. out_port wires straight to the board HEXn pins.

---
 rtl/hex_display_pkg.sv | 38 +++
 rtl/hex_display_ctrl_decoder.sv | 20 ++
 rtl/hex_display_ctrl.sv | 135 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared register map, segment width and hex glyph table for the hex display controller.
// Segment bit 0 = a ... bit 6 = g, active-high logical encoding.
package hex_display_pkg;

   localparam int SEG_W = 7;

   localparam logic [3:0] ADDR_DATA     = 4'd0;
   localparam logic [3:0] ADDR_MODE     = 4'd1;
   localparam logic [3:0] ADDR_BLANK    = 4'd2;
   localparam logic [3:0] ADDR_BLINK    = 4'd3;
   localparam logic [3:0] ADDR_DIV      = 4'd4;
   localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

   // b and d are the lower-case glyphs so they stay distinct from 8 and 0.
   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
      logic [SEG_W-1:0] seg;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_display_ctrl_decoder.sv
// Per-digit segment selection: hex glyph or raw pattern, forced dark when blanked or blinked off.
// Output is logical (1 = lit); pin polarity is applied by the parent.
module hex_seg_decoder
   import hex_display_pkg::*;
(
   input  logic [3:0]       i_nibble,
   input  logic [SEG_W-1:0] i_raw,
   input  logic             i_mode,
   input  logic             i_dark,
   output logic [SEG_W-1:0] o_seg
);

   always_comb begin
      o_seg = '0;
      if (!i_dark) begin
         o_seg = i_mode ? i_raw : seg_decode(i_nibble);
      end
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with hex/raw modes and blanking.
// Define HEX_BLINK_EN to build the BLINK/BLINK_DIV registers and the blink prescaler.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int         NUM_DIGITS  = 6,
   parameter bit         ACTIVE_LOW  = 1'b1,
   parameter logic [7:0] RESET_BLANK = 8'hFF,
   parameter int         DIV_W       = 24
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [3:0]                  address,
   input  logic                        chipselect,
   input  logic                        write_n,
   input  logic [3:0]                  byteenable,
   input  logic [31:0]                 writedata,
   output logic [31:0]                 readdata,
   output logic [SEG_W*NUM_DIGITS-1:0] out_port
);

   localparam int DATA_W = 4 * NUM_DIGITS;

   logic [DATA_W-1:0]     r_data;
   logic [NUM_DIGITS-1:0] r_mode;
   logic [NUM_DIGITS-1:0] r_blank;
   logic [SEG_W-1:0]      r_raw [NUM_DIGITS];

   logic                  w_wr;
   logic [31:0]           w_be_mask;
   logic [31:0]           w_data32;
   logic [DATA_W-1:0]     w_data_nxt;
   logic [NUM_DIGITS-1:0] w_blink_dark;
   logic [SEG_W-1:0]      w_seg [NUM_DIGITS];

   assign w_wr = chipselect & ~write_n;

   // Merge only the enabled byte lanes into the current DATA value.
   always_comb begin
      w_be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
      w_data32  = '0;
      w_data32[DATA_W-1:0] = r_data;
      w_data32  = (w_data32 & ~w_be_mask) | (writedata & w_be_mask);
      w_data_nxt = w_data32[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data  <= '0;
         r_mode  <= '0;
         r_blank <= RESET_BLANK[NUM_DIGITS-1:0];
         for (int i = 0; i < NUM_DIGITS; i++) r_raw[i] <= '0;
      end else if (w_wr) begin
         if (address == ADDR_DATA)  r_data  <= w_data_nxt;
         if (address == ADDR_MODE)  r_mode  <= writedata[NUM_DIGITS-1:0];
         if (address == ADDR_BLANK) r_blank <= writedata[NUM_DIGITS-1:0];
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == ADDR_RAW_BASE + 4'(i)) r_raw[i] <= writedata[SEG_W-1:0];
         end
      end
   end

`ifdef HEX_BLINK_EN
   logic [NUM_DIGITS-1:0] r_blink;
   logic [DIV_W-1:0]      r_div;
   logic [DIV_W-1:0]      r_cnt;
   logic                  r_phase;
   logic                  w_div_we;

   assign w_div_we = w_wr && (address == ADDR_DIV);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink <= '0;
         r_div   <= '0;
      end else if (w_wr) begin
         if (address == ADDR_BLINK) r_blink <= writedata[NUM_DIGITS-1:0];
         if (address == ADDR_DIV)   r_div   <= writedata[DIV_W-1:0];
      end
   end

   // A DIV write restarts the count even on a terminal edge; the phase toggle still happens.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (r_div == '0) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else begin
         if (r_cnt == r_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
         if (w_div_we) r_cnt <= '0;
      end
   end

   assign w_blink_dark = r_blink & {NUM_DIGITS{r_phase}};
`else
   assign w_blink_dark = '0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:  readdata = 32'(r_data);
         ADDR_MODE:  readdata = 32'(r_mode);
         ADDR_BLANK: readdata = 32'(r_blank);
`ifdef HEX_BLINK_EN
         ADDR_BLINK: readdata = 32'(r_blink);
         ADDR_DIV:   readdata = 32'(r_div);
`endif
         default: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (address == ADDR_RAW_BASE + 4'(i)) readdata = 32'(r_raw[i]);
            end
         end
      endcase
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex_seg_decoder u_dec (
         .i_nibble (r_data[4*g +: 4]),
         .i_raw    (r_raw[g]),
         .i_mode   (r_mode[g]),
         .i_dark   (r_blank[g] | w_blink_dark[g]),
         .o_seg    (w_seg[g])
      );
      assign out_port[SEG_W*g +: SEG_W] = ACTIVE_LOW ? ~w_seg[g] : w_seg[g];
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: stimulus pushes expected reads/pin values, a negedge monitor compares.
// Blink checks are built when HEX_BLINK_EN is defined; otherwise addresses 3 and 4 must read 0.
module tb_hex_display_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [3:0]  byteenable = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [41:0] out_port;

   logic [63:0] exp_q[$];
   logic        kind_q[$];
   string       name_q[$];
   logic        mon_valid = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   localparam logic [41:0] ALL_DARK = 42'h3FF_FFFF_FFFF;

   hex_display_ctrl #(
      .NUM_DIGITS (6),
      .ACTIVE_LOW (1'b1),
      .RESET_BLANK(8'hFF),
      .DIV_W      (24)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .byteenable(byteenable),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port)
   );

   always #5 clk = ~clk;

   // Monitor: kind 0 compares readdata, kind 1 compares out_port.
   always @(negedge clk) begin
      if (mon_valid) begin
         logic [63:0] exp_v;
         logic [63:0] act_v;
         logic        kind;
         string       nm;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: no expected entry");
         end else begin
            exp_v = exp_q.pop_front();
            kind  = kind_q.pop_front();
            nm    = name_q.pop_front();
            act_v = kind ? 64'(out_port) : 64'(readdata);
            if (act_v !== exp_v) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
            end
         end
      end
   end

   function automatic logic [41:0] pack(input logic [6:0] g5, g4, g3, g2, g1, g0);
      return {g5, g4, g3, g2, g1, g0};
   endfunction

   task automatic push_chk(input logic kind, input logic [63:0] exp_v, input string nm);
      exp_q.push_back(exp_v);
      kind_q.push_back(kind);
      name_q.push_back(nm);
      mon_valid = 1'b1;
      @(negedge clk); #1;
      mon_valid = 1'b0;
   endtask

   task automatic check_rd(input logic [3:0] a, input logic [31:0] exp_v, input string nm);
      @(posedge clk); #1;
      address = a;
      push_chk(1'b0, 64'(exp_v), nm);
   endtask

   task automatic check_out(input logic [41:0] exp_v, input string nm);
      @(posedge clk); #1;
      push_chk(1'b1, 64'(exp_v), nm);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      @(posedge clk); #1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      byteenable = be;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      byteenable = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      check_out(ALL_DARK, "reset_out");
      check_rd(4'd2, 32'h0000_003F, "reset_blank");
      check_rd(4'd0, 32'h0, "reset_data");
      check_rd(4'd1, 32'h0, "reset_mode");

      // Hex decode, all sixteen glyphs
      bus_write(4'd2, 32'h0, 4'hF);
      bus_write(4'd0, 32'h00A5_4321, 4'hF);
      check_out(~pack(7'h77, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06), "dec_a54321");
      check_rd(4'd0, 32'h00A5_4321, "rd_data");
      bus_write(4'd0, 32'h00FE_DCB0, 4'hF);
      check_out(~pack(7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h3F), "dec_fedcb0");
      bus_write(4'd0, 32'h0098_7654, 4'hF);
      check_out(~pack(7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66), "dec_987654");

      // Byte-lane gating; DATA holds 24 bits with six digits
      bus_write(4'd0, 32'h1111_1111, 4'hF);
      check_rd(4'd0, 32'h0011_1111, "data_full");
      bus_write(4'd0, 32'hFFFF_FFFF, 4'b0010);
      check_rd(4'd0, 32'h0011_FF11, "data_lane1");
      bus_write(4'd0, 32'h0, 4'b0000);
      check_rd(4'd0, 32'h0011_FF11, "data_be0");

      // Raw mode and blanking
      bus_write(4'd0, 32'h0, 4'hF);
      bus_write(4'd1, 32'h1, 4'h0);
      bus_write(4'd8, 32'h49, 4'h0);
      check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h49), "raw_digit0");
      check_rd(4'd8, 32'h49, "rd_raw0");
      check_rd(4'd1, 32'h1, "rd_mode");
      bus_write(4'd2, 32'h1, 4'h0);
      check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00), "blank_digit0");
      bus_write(4'd14, 32'h7F, 4'hF);
      check_rd(4'd14, 32'h0, "rd_raw_unmapped");
      bus_write(4'd5, 32'hFFFF_FFFF, 4'hF);
      check_rd(4'd5, 32'h0, "rd_addr5");
      bus_write(4'd1, 32'h0, 4'h0);
      bus_write(4'd2, 32'h0, 4'h0);
      check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), "all_zero_glyph");

`ifdef HEX_BLINK_EN
      // Half-period of 4 cycles, then a mid-count DIV rewrite, then DIV=0
      bus_write(4'd3, 32'h1, 4'h0);
      bus_write(4'd4, 32'h3, 4'h0);
      for (int k = 1; k <= 12; k++) begin
         if (((k / 4) % 2) == 1)
            check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00), $sformatf("blink_dark_%0d", k));
         else
            check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), $sformatf("blink_lit_%0d", k));
      end
      bus_write(4'd4, 32'h3, 4'h0);
      for (int k = 1; k <= 4; k++) begin
         if (k < 4)
            check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00), $sformatf("restart_dark_%0d", k));
         else
            check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), "restart_lit");
      end
      check_rd(4'd3, 32'h1, "rd_blink");
      check_rd(4'd4, 32'h3, "rd_div");
      bus_write(4'd4, 32'h0, 4'h0);
      for (int k = 1; k <= 6; k++) begin
         check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), $sformatf("div0_lit_%0d", k));
      end
      bus_write(4'd4, 32'h2, 4'h0);
`else
      bus_write(4'd3, 32'h1, 4'hF);
      bus_write(4'd4, 32'h3, 4'hF);
      check_rd(4'd3, 32'h0, "rd_blink_absent");
      check_rd(4'd4, 32'h0, "rd_div_absent");
      check_out(~pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), "no_blink_effect");
`endif

      // Reset asserted during a write: values return at once and the write is lost
      bus_write(4'd0, 32'h0012_3456, 4'hF);
      @(posedge clk); #1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 4'd2;
      writedata  = 32'h0;
      byteenable = 4'hF;
      reset      = 1'b1;
      push_chk(1'b0, 64'h3F, "rst_mid_blank");
      push_chk(1'b1, 64'(ALL_DARK), "rst_mid_out");
      @(posedge clk); #1;
      reset      = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      byteenable = '0;
      check_rd(4'd0, 32'h0, "rst_data");
      check_rd(4'd8, 32'h0, "rst_raw0");
      check_rd(4'd2, 32'h3F, "rst_blank_kept");
      check_out(ALL_DARK, "rst_out");
`ifdef HEX_BLINK_EN
      check_rd(4'd4, 32'h0, "rst_div");
`endif

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
